// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan path.
//   SEG_HEX   : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_BLANK : all segments off
//   clog2()   : ceiling log2 for sizing counters and selects
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n lives at bits [n*7 +: 7]; listed F down to 0.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern, with a force-dark override.
//   nib_i   : hex value to show
//   blank_i : 1 turns every segment off
//   seg_o   : {g,f,e,d,c,b,a}, active low
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_HEX[nib_i];
        if (blank_i) seg_o = SEG_BLANK;
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment scanner. Snapshots one of NUM_PAGES hex words at
// frame boundaries and scans it across NUM_DIGITS active-low digits.
//   clk, rst_n   : clock, async active-low reset
//   page_data    : NUM_PAGES words of NUM_DIGITS nibbles, page p at p*NUM_DIGITS*4
//   page_sel     : page to snapshot (out-of-range selects page 0)
//   lz_blank     : leading-zero blanking enable
//   blank_mask   : per-digit force-dark
//   dp_mask      : per-digit decimal point
//   freeze       : suppress frame-boundary snapshot loads
//   seg_n, dp_n, an_n : registered display drive, active low
//   frame_start  : one-cycle pulse coincident with a snapshot load
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_PAGES  = 4,
    parameter int SCAN_DIV   = 12500
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PAGES*NUM_DIGITS*4-1:0]        page_data,
    input  logic [clog2((NUM_PAGES > 1) ? NUM_PAGES : 2)-1:0] page_sel,
    input  logic                                     lz_blank,
    input  logic [NUM_DIGITS-1:0]                    blank_mask,
    input  logic [NUM_DIGITS-1:0]                    dp_mask,
    input  logic                                     freeze,
    output logic [6:0]                               seg_n,
    output logic                                     dp_n,
    output logic [NUM_DIGITS-1:0]                    an_n,
    output logic                                     frame_start
);

    localparam int W     = NUM_DIGITS * 4;
    localparam int SEL_W = clog2((NUM_PAGES > 1) ? NUM_PAGES : 2);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam int DIV_W = clog2(SCAN_DIV);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  init_pending_q;
    logic [W-1:0]          snap_word_q;
    logic                  snap_lz_q;
    logic [NUM_DIGITS-1:0] snap_blank_q, snap_dp_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d, fs_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick, load, dark, zero_above;
    logic [SEL_W-1:0]      sel_page;
    logic [W-1:0]          sel_word;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic [3:0]            nib;
    logic [6:0]            seg_dec;

    always_comb begin
        // Prescaler holds during the init-load cycle so the first digit gets a
        // full SCAN_DIV slot like every other.
        tick      = !init_pending_q && (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        div_cnt_d = div_cnt_q;
        if (!init_pending_q) div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

        idx_d = idx_q;
        if (tick) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

        load = init_pending_q || (tick && (idx_q == IDX_W'(NUM_DIGITS - 1)) && !freeze);

        sel_page = (int'(page_sel) < NUM_PAGES) ? page_sel : '0;
        sel_word = page_data[int'(sel_page)*W +: W];

        // Digit d is a leading zero if it and every digit above it are zero.
        zero_above = 1'b1;
        lz_dark    = '0;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            zero_above = zero_above & (snap_word_q[d*4 +: 4] == 4'h0);
            lz_dark[d] = zero_above;
        end

        nib  = snap_word_q[int'(idx_q)*4 +: 4];
        dark = snap_blank_q[idx_q] | (snap_lz_q & lz_dark[idx_q]);

        // Display stays dark until the first snapshot is in place.
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (!init_pending_q) begin
            seg_d = seg_dec;
            dp_d  = ~snap_dp_q[idx_q];
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    seg7_decode u_dec (
        .nib_i   (nib),
        .blank_i (dark),
        .seg_o   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= '0;
            idx_q          <= '0;
            init_pending_q <= 1'b1;
            snap_word_q    <= '0;
            snap_lz_q      <= 1'b0;
            snap_blank_q   <= '0;
            snap_dp_q      <= '0;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
            an_q           <= '1;
            fs_q           <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            idx_q          <= idx_d;
            init_pending_q <= 1'b0;
            fs_q           <= load;
            if (load) begin
                snap_word_q  <= sel_word;
                snap_lz_q    <= lz_blank;
                snap_blank_q <= blank_mask;
                snap_dp_q    <= dp_mask;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg_n       = seg_q;
    assign dp_n        = dp_q;
    assign an_n        = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int NP = 2;
    localparam int SD = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [15:0]    page0 = 16'h1F08, page1 = 16'h00A0;
    logic [0:0]     page_sel = 1'b0;
    logic           lz_blank = 1'b0;
    logic [ND-1:0]  blank_mask = '0, dp_mask = '0;
    logic           freeze = 1'b0;
    logic [6:0]     seg_n;
    logic           dp_n;
    logic [ND-1:0]  an_n;
    logic           frame_start;

    int n_chk = 0;
    int n_fail = 0;

    // Expected sample: {an_n, seg_n, dp_n, frame_start}
    logic [12:0] sb_q[$];

    logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seg7_scan_mux #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .SCAN_DIV(SD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .page_data   ({page1, page0}),
        .page_sel    (page_sel),
        .lz_blank    (lz_blank),
        .blank_mask  (blank_mask),
        .dp_mask     (dp_mask),
        .freeze      (freeze),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Queue one full frame of expected samples for the given snapshot.
    task automatic push_frame(input logic [15:0] word, input logic lz,
                              input logic [ND-1:0] bm, input logic [ND-1:0] dpm,
                              input logic fs_last);
        int hi;
        logic [6:0] seg;
        logic [ND-1:0] an;
        hi = 0;
        for (int d = 0; d < ND; d++) if (word[d*4 +: 4] != 4'h0) hi = d;
        for (int d = 0; d < ND; d++) begin
            seg = hex_tbl[word[d*4 +: 4]];
            if (bm[d] || (lz && d > hi)) seg = 7'h7F;
            an = '1;
            an[d] = 1'b0;
            for (int c = 0; c < SD; c++)
                sb_q.push_back({an, seg, ~dpm[d], (d == ND-1 && c == SD-1) ? fs_last : 1'b0});
        end
    endtask

    task automatic drain(input int n, input string tag);
        logic [12:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk(tag, {19'd0, an_n, seg_n, dp_n, frame_start}, {19'd0, e});
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 chk("reset", {19'd0, an_n, seg_n, dp_n, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});

        // Release: edge 1 init load, display still dark
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("init_load", {19'd0, an_n, seg_n, dp_n, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b1});

        // Frame A: page0 1F08 -> 8,0,F,1
        push_frame(16'h1F08, 1'b0, '0, '0, 1'b1);
        drain(ND*SD, "frameA");

        // Frame B: switch page and LZ mid-frame, B unchanged
        push_frame(16'h1F08, 1'b0, '0, '0, 1'b1);
        drain(6, "frameB");
        page_sel = 1'b1;
        lz_blank = 1'b1;
        drain(ND*SD - 6, "frameB");

        // Frame C: page1 00A0 with LZ; zero page1 mid-frame is invisible
        push_frame(16'h00A0, 1'b1, '0, '0, 1'b1);
        drain(5, "frameC");
        page1 = 16'h0000;
        drain(ND*SD - 5, "frameC");

        // Frame D: all zero with LZ; freeze set before its wrap
        push_frame(16'h0000, 1'b1, '0, '0, 1'b0);
        drain(3, "frameD");
        freeze = 1'b1;
        page1  = 16'h1234;
        drain(ND*SD - 3, "frameD");

        // Frames E,F frozen; G releases freeze mid-frame
        push_frame(16'h0000, 1'b1, '0, '0, 1'b0);
        drain(ND*SD, "frozenE");
        push_frame(16'h0000, 1'b1, '0, '0, 1'b0);
        drain(ND*SD, "frozenF");
        push_frame(16'h0000, 1'b1, '0, '0, 1'b1);
        drain(2, "frozenG");
        freeze = 1'b0;
        drain(ND*SD - 2, "frozenG");

        // Frame H: new value; masks changed mid-frame
        push_frame(16'h1234, 1'b1, '0, '0, 1'b1);
        drain(7, "frameH");
        lz_blank   = 1'b0;
        blank_mask = 4'b0100;
        dp_mask    = 4'b0001;
        drain(ND*SD - 7, "frameH");

        // Frame I: digit 2 dark, dp only on digit 0; reset mid-digit 2
        push_frame(16'h1234, 1'b0, 4'b0100, 4'b0001, 1'b1);
        drain(2*SD + 2, "frameI");
        sb_q.delete();
        rst_n = 1'b0;
        #1 chk("midreset", {19'd0, an_n, seg_n, dp_n, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reinit", {19'd0, an_n, seg_n, dp_n, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b1});
        push_frame(16'h1234, 1'b0, 4'b0100, 4'b0001, 1'b1);
        drain(ND*SD, "frameK");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised multiplexed seven-segment scanner for the board display path of the MIPS pipeline top level. Selects one of several hex pages, such as PC, next PC, register or memory data, snapshots it at frame boundaries so a digit scan never shows a torn value, and time-multiplexes NUM_DIGITS active-low digits. It adds leading-zero blanking, per-digit blank and decimal-point masks, and a freeze control beyond the current fixed 8-digit display.

## Interface
Parameters:
- NUM_DIGITS, 8: digits scanned; 2..8.
- NUM_PAGES, 4: selectable data pages; 1..8.
- SCAN_DIV, 12500: clk cycles per digit slot; ≥2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- page_data, in, NUM_PAGES*NUM_DIGITS*4: page p occupies bits [p*NUM_DIGITS*4 +: NUM_DIGITS*4]; nibble d drives digit d (digit 0 is rightmost).
- page_sel, in, clog2(NUM_PAGES) (min 1): requested page; values ≥NUM_PAGES select page 0.
- lz_blank, in, 1: enable leading-zero blanking.
- blank_mask, in, NUM_DIGITS: 1 forces that digit dark.
- dp_mask, in, NUM_DIGITS: 1 lights that digit's decimal point.
- freeze, in, 1: hold the current snapshot; scanning continues.
- seg_n, out, 7: {g,f,e,d,c,b,a}, active low.
- dp_n, out, 1: decimal point, active low.
- an_n, out, NUM_DIGITS: digit enables, active low, at most one low.
- frame_start, out, 1: one-cycle pulse when a snapshot is loaded.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `div_cnt`==SCAN_DIV-1.
- Digit index `idx` advances by 1 on each `tick` and wraps from NUM_DIGITS-1 to 0.
- Snapshot load event:
  - fires on the first clk edge after rst_n deasserts (`init_pending` flag);
  - fires on every `tick` with `idx`==NUM_DIGITS-1, unless `freeze`=1;
  - latches the selected page word, lz_blank, blank_mask and dp_mask into the snapshot registers;
  - pulses `frame_start` in the same cycle as the load register update.
- freeze=1 suppresses the wrap-time load only; the init load always happens.
- Leading-zero blanking computed from the snapshot:
  - with lz_blank=1, digit d is dark if every snapshot nibble at index ≥d is 0;
  - digit 0 is never LZ-blanked, so all zeros displays "0".
- Digit dark means seg_n=7'h7F. The anode stays enabled. dp_n still follows dp_mask.
- Hex decode, active low: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Reset values: div_cnt=0, idx=0, snapshot=0, init_pending=1, seg_n=7'h7F, dp_n=1, an_n=all 1, frame_start=0.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronous); there is no partial-frame output.

## Timing
- Outputs are registered. seg_n, dp_n and an_n reflect `idx` and the snapshot one cycle after either changes.
- After reset release:
  - edge 1: init load, frame_start=1;
  - edge 2: an_n[0]=0 with digit 0 of the snapshot.
- Each digit is driven for exactly SCAN_DIV cycles. A frame is NUM_DIGITS*SCAN_DIV cycles.
- Wrap `tick`: idx→0 and the snapshot loads on the same edge. The new frame's digit 0 appears one edge later.
- page_sel or mask changes mid-frame have no visible effect until the next load.
- No anode overlap: an_n changes in a single registered update.

## Structure
- Package `seg7_pkg`: 16-entry active-low hex segment constant table, SEG_BLANK=7'h7F, and a clog2 helper function.
- Sub-module `seg7_decode`: combinational nibble+blank→seg_n, using the package table.
- Top: prescaler, index counter, snapshot/LZ logic, output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, NUM_PAGES=2, SCAN_DIV=4.
- Reset release with page0=16'h1F08, page_sel=0:
  - frame_start on edge 1;
  - an_n=1110 with seg_n=0000000 ("8") for 4 cycles;
  - then digits 1..3 show 1000000 ("0"), 0001110 ("F") and 1111001 ("1"), each for 4 cycles.
- page1=16'h00A0, lz_blank=1, page_sel switched to 1 mid-frame:
  - the current frame is unchanged;
  - the next frame shows digits 3,2 dark, digit 1 "A" (0001000) and digit 0 "0".
- All-zero page with lz_blank=1: digit 0 shows 1000000 and digits 1..3 show 7'h7F.
- freeze=1 then page data changed: the display keeps the old value across ≥3 frames with no frame_start. On freeze=0 the next wrap loads the new value.
- blank_mask=4'b0100, dp_mask=4'b0001: digit 2 seg_n=7'h7F; dp_n=0 only while an_n=1110.
- rst_n pulsed low mid-digit 2: outputs go dark immediately and restart from digit 0 with a new init load.
